fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage 16-bit RISC pipeline. It owns the program counter, reads 16-bit instruction words from instruction memory, and builds the registered 69-bit IF/ID bundle that the decode stage consumes. It handles stall, flush, branch redirect, two-word (immediate) instructions and interrupt-pin latching.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMM_OPC, 2'b11, value of instruction bits [15:14] that marks a two-word instruction
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous, active-low reset
- Stall  in  1  hold PC and IF/ID bundle (driven by decode stall)
- Flush  in  1  replace IF/ID bundle with a bubble
- Branch  in  1  redirect PC to BranchTarget
- BranchTarget  in  32  redirect word address
- InPort  in  16  external input port sample
- Interrupt  in  1  external interrupt request (level, sampled)
- ImemData  in  16  instruction word at ImemAddr (combinational read)
- ImemAddr  out  32  current PC (word address)
- Out  out  69  IF/ID bundle: [68:53] InPort sample, [52:21] next-PC (address after this word), [20:5] instruction word, [4] interrupt, [3] immediate-word flag, [2] valid, [1:0] 2'b00

## Operation
- ImemAddr = PC, combinationally.
- Priority per edge: Rst low > Branch > Flush > Stall > normal fetch.
- Reset (Rst==0 at edge): PC <= RESET_PC, Out <= 69'b0, FSM <= FETCH, interrupt latch cleared.
- FSM states FETCH, IMM.
  - FETCH, normal: Out <= {InPort, PC+1, ImemData, IntFlag, 1'b0, 1'b1, 2'b00}; PC <= PC+1; if ImemData[15:14]==IMM_OPC go IMM.
  - IMM, normal: Out <= {InPort, PC+1, ImemData, 1'b0, 1'b1, 1'b1, 2'b00}; PC <= PC+1; go FETCH. Interrupt never issued on an immediate word.
- Branch: PC <= BranchTarget; Out <= bubble (all zero); FSM <= FETCH. Overrides Stall and Flush in the same cycle.
- Flush without Branch: Out <= bubble; PC <= PC+1 and FSM advance as in normal fetch of the current word being discarded? No: PC holds, FSM <= FETCH.
- Stall without Branch/Flush: PC, Out, FSM hold unchanged.
- Interrupt latch: set on any edge with Interrupt==1; IntFlag = latch | Interrupt. Cleared on the edge where a FETCH-state word issues with bit [4]=1. Held through stalls, flushes, branches and IMM words.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFF -> 0 with no flag.

## Timing
- One-cycle latency: word at ImemAddr in cycle n appears on Out after edge n.
- Stall is honoured in the same cycle it is asserted; fetch resumes the cycle after deassertion with no lost or duplicated word.
- Branch takes effect on the next edge; the first target word appears on Out two edges after Branch asserts (one bubble).
- Reset mid-IMM: FSM returns to FETCH; the pending immediate word is discarded.
- Out reset value: 69'b0 (valid=0). ImemAddr reset value: RESET_PC.

## Structure
- Shared package fetch_pkg: bundle field offsets (INPORT_HI/LO, ADDR_HI/LO, INSTR_HI/LO, INT_BIT, IMMW_BIT, VALID_BIT), FSM state encoding (FETCH=1'b0, IMM=1'b1), BUNDLE_W=69.
- One sub-module: pc_register (32-bit register with sync active-low reset, load, hold and increment controls).

## Test plan
- Reset, RESET_PC=0, memory words 0x1234,0x2345 -> ImemAddr=0; after two edges Out[20:5]=0x2345, Out[52:21]=2, valid=1.
- Word 0xC001 at addr 4 then 0x00FF -> first bundle imm flag 0, second bundle Out[20:5]=0x00FF, Out[3]=1, FSM back to FETCH.
- Stall held 3 cycles at PC=7 -> ImemAddr stays 7, Out unchanged; release -> word 7 issued exactly once.
- Branch to 0x100 with Stall=1 simultaneously -> next Out = bubble, ImemAddr=0x100; following Out carries word 0x100.
- One-cycle Interrupt pulse during IMM state -> immediate bundle has bit4=0; next FETCH bundle bit4=1; subsequent bundle bit4=0.
- Rst low while in IMM with PC=0x20 -> Out=0, PC=RESET_PC, state FETCH.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: IF/ID bundle layout and FSM encoding.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package fetch_pkg;

   localparam int BUNDLE_W  = 69;

   // IF/ID bundle field offsets
   localparam int INPORT_HI = 68;
   localparam int INPORT_LO = 53;
   localparam int ADDR_HI   = 52;
   localparam int ADDR_LO   = 21;
   localparam int INSTR_HI  = 20;
   localparam int INSTR_LO  = 5;
   localparam int INT_BIT   = 4;
   localparam int IMMW_BIT  = 3;
   localparam int VALID_BIT = 2;

   // Fetch FSM: FETCH issues opcode words, IMM issues the trailing immediate word
   typedef enum logic {
      FETCH = 1'b0,
      IMM   = 1'b1
   } fetch_state_t;

   // IF/ID bundle as seen by decode; field order matches the offsets above
   typedef struct packed {
      logic [15:0] inport;
      logic [31:0] next_pc;
      logic [15:0] instr;
      logic        intr;
      logic        immw;
      logic        valid;
      logic [1:0]  rsvd;
   } if_id_t;

   // Assemble a valid bundle; reserved bits are always zero
   function automatic if_id_t build_bundle(
      input logic [15:0] inport,
      input logic [31:0] next_pc,
      input logic [15:0] instr,
      input logic        intr,
      input logic        immw
   );
      if_id_t b;
      b.inport  = inport;
      b.next_pc = next_pc;
      b.instr   = instr;
      b.intr    = intr;
      b.immw    = immw;
      b.valid   = 1'b1;
      b.rsvd    = 2'b00;
      return b;
   endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter register with load, increment and hold; also exposes PC+1 combinationally.
// Latency: new value visible one cycle after the controlling edge; pc_plus1 is combinational.
// Backpressure: hold when neither load nor inc is asserted (caller maps stall/flush to hold).
module pc_register #(
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        inc,
   output logic [31:0] pc,
   output logic [31:0] pc_plus1
);

   logic [31:0] pc_q;

   // 32-bit increment wraps silently from all-ones to zero
   assign pc_plus1 = pc_q + 32'd1;
   assign pc       = pc_q;

   // PC update: reset beats load beats increment; otherwise hold
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= RESET_VAL;
      end else if (load) begin
         pc_q <= load_val;
      end else if (inc) begin
         pc_q <= pc_plus1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads imem, registers the 69-bit IF/ID bundle for decode.
// Latency: one cycle from ImemAddr to Out; a branch costs one bubble before the target word.
// Backpressure: Stall holds PC, bundle and FSM in the same cycle; Flush/Branch insert a bubble.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [1:0]  IMM_OPC  = 2'b11
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                Stall,
   input  logic                Flush,
   input  logic                Branch,
   input  logic [31:0]         BranchTarget,
   input  logic [15:0]         InPort,
   input  logic                Interrupt,
   input  logic [15:0]         ImemData,
   output logic [31:0]         ImemAddr,
   output logic [BUNDLE_W-1:0] Out
);

   logic [31:0]  pc;
   logic [31:0]  pc_plus1;
   logic         advance;
   logic         int_flag;
   logic         int_latch_q;
   fetch_state_t state_q;
   if_id_t       out_q;

   // A word is consumed only on an undisturbed cycle; branch loads instead
   assign advance  = !Branch && !Flush && !Stall;

   // A pending request or one arriving this cycle can ride on the next opcode word
   assign int_flag = int_latch_q | Interrupt;

   assign ImemAddr = pc;
   assign Out      = out_q;

   pc_register #(
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk      (Clk),
      .rst_n    (Rst),
      .load     (Branch),
      .load_val (BranchTarget),
      .inc      (advance),
      .pc       (pc),
      .pc_plus1 (pc_plus1)
   );

   // Fetch FSM with registered IF/ID bundle and interrupt latch
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q     <= FETCH;
         out_q       <= '0;
         int_latch_q <= 1'b0;
      end else if (Branch || Flush) begin
         // Bubble; any half-fetched two-word instruction is abandoned
         state_q     <= FETCH;
         out_q       <= '0;
         int_latch_q <= int_flag;
      end else if (Stall) begin
         int_latch_q <= int_flag;
      end else begin
         case (state_q)
            FETCH: begin
               out_q       <= build_bundle(InPort, pc_plus1, ImemData, int_flag, 1'b0);
               // The request is delivered with this word, so nothing remains pending
               int_latch_q <= 1'b0;
               state_q     <= (ImemData[15:14] == IMM_OPC) ? IMM : FETCH;
            end
            IMM: begin
               // Immediate words never carry an interrupt; keep it for the next opcode
               out_q       <= build_bundle(InPort, pc_plus1, ImemData, 1'b0, 1'b1);
               int_latch_q <= int_flag;
               state_q     <= FETCH;
            end
            default: begin
               out_q       <= '0;
               int_latch_q <= int_flag;
               state_q     <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle reference model feeding a scoreboard, plus directed checks.
// Latency: expected bundle is pushed before each edge and popped one edge later.
// Backpressure: stall/flush/branch exercised both directed and randomly.
module tb_fetch_stage;
   import fetch_pkg::*;

   logic                Clk;
   logic                Rst;
   logic                Stall;
   logic                Flush;
   logic                Branch;
   logic [31:0]         BranchTarget;
   logic [15:0]         InPort;
   logic                Interrupt;
   logic [15:0]         ImemData;
   logic [31:0]         ImemAddr;
   logic [BUNDLE_W-1:0] Out;

   logic [15:0] mem [0:1023];

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0]         m_pc;
   logic                m_st;
   logic                m_lat;
   logic [BUNDLE_W-1:0] m_out;
   logic [BUNDLE_W-1:0] sb_q [$];
   logic [BUNDLE_W-1:0] saved;

   fetch_stage dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .Stall        (Stall),
      .Flush        (Flush),
      .Branch       (Branch),
      .BranchTarget (BranchTarget),
      .InPort       (InPort),
      .Interrupt    (Interrupt),
      .ImemData     (ImemData),
      .ImemAddr     (ImemAddr),
      .Out          (Out)
   );

   assign ImemData = mem[ImemAddr[9:0]];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [BUNDLE_W-1:0] got, input logic [BUNDLE_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Model one edge from current inputs, push expectation, clock, then compare
   task automatic tick();
      logic        intf;
      logic [15:0] w;
      logic [BUNDLE_W-1:0] e;
      intf = m_lat | Interrupt;
      w    = mem[m_pc[9:0]];
      if (!Rst) begin
         m_out = '0; m_pc = 32'h0; m_st = 1'b0; m_lat = 1'b0;
      end else if (Branch) begin
         m_out = '0; m_pc = BranchTarget; m_st = 1'b0; m_lat = intf;
      end else if (Flush) begin
         m_out = '0; m_st = 1'b0; m_lat = intf;
      end else if (Stall) begin
         m_lat = intf;
      end else if (!m_st) begin
         m_out = {InPort, m_pc + 32'd1, w, intf, 1'b0, 1'b1, 2'b00};
         m_lat = 1'b0;
         m_st  = (w[15:14] == 2'b11);
         m_pc  = m_pc + 32'd1;
      end else begin
         m_out = {InPort, m_pc + 32'd1, w, 1'b0, 1'b1, 1'b1, 2'b00};
         m_lat = intf;
         m_st  = 1'b0;
         m_pc  = m_pc + 32'd1;
      end
      sb_q.push_back(m_out);
      @(posedge Clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 69'd1, 69'd0);
      end else begin
         e = sb_q.pop_front();
         check("sb_out", Out, e);
      end
      check("sb_addr", {37'b0, ImemAddr}, {37'b0, m_pc});
   endtask

   task automatic idle_inputs();
      Rst = 1'b1; Stall = 1'b0; Flush = 1'b0; Branch = 1'b0;
      BranchTarget = 32'h0; Interrupt = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[0]     = 16'h1234; mem[1]     = 16'h2345; mem[2]     = 16'h0002; mem[3] = 16'h0003;
      mem[4]     = 16'hC001; mem[5]     = 16'h00FF; mem[6]     = 16'h0006; mem[7] = 16'h0777;
      mem[8]     = 16'h0888; mem[9]     = 16'h0009;
      mem[16'h100] = 16'h0ABC; mem[16'h101] = 16'h0101; mem[16'h102] = 16'hC0AA;
      mem[16'h103] = 16'h1111; mem[16'h104] = 16'h0104; mem[16'h105] = 16'h0105;
      mem[16'h01F] = 16'hC0BB; mem[16'h020] = 16'h2020; mem[1023]     = 16'h0555;

      idle_inputs();
      Rst = 1'b0; InPort = 16'hA5A5;
      m_pc = 32'hX; m_st = 1'b0; m_lat = 1'b0; m_out = '0;

      // Reset
      tick();
      check("rst_out", Out, 69'd0);
      check("rst_addr", {37'b0, ImemAddr}, 69'd0);
      Rst = 1'b1;

      // Straight-line fetch
      tick();
      check("w0_instr", Out[INSTR_HI:INSTR_LO], 69'h1234);
      tick();
      check("w1_instr", Out[INSTR_HI:INSTR_LO], 69'h2345);
      check("w1_next", Out[ADDR_HI:ADDR_LO], 69'd2);
      check("w1_valid", Out[VALID_BIT], 69'd1);
      tick(); tick();

      // Two-word instruction at 4/5
      InPort = 16'h1357;
      tick();
      check("imm_op_flag", Out[IMMW_BIT], 69'd0);
      check("imm_op_instr", Out[INSTR_HI:INSTR_LO], 69'hC001);
      tick();
      check("imm_word", Out[INSTR_HI:INSTR_LO], 69'h00FF);
      check("imm_word_flag", Out[IMMW_BIT], 69'd1);
      check("imm_inport", Out[INPORT_HI:INPORT_LO], 69'h1357);
      tick();
      check("after_imm_flag", Out[IMMW_BIT], 69'd0);

      // Stall three cycles at PC=7
      saved = Out;
      Stall = 1'b1;
      tick(); tick(); tick();
      check("stall_addr", {37'b0, ImemAddr}, 69'd7);
      check("stall_hold", Out, saved);
      Stall = 1'b0;
      tick();
      check("unstall_w7", Out[INSTR_HI:INSTR_LO], 69'h0777);
      tick();
      check("unstall_w8", Out[INSTR_HI:INSTR_LO], 69'h0888);

      // Branch overrides Stall
      Branch = 1'b1; Stall = 1'b1; BranchTarget = 32'h100;
      tick();
      check("br_bubble", Out, 69'd0);
      check("br_addr", {37'b0, ImemAddr}, 69'h100);
      Branch = 1'b0; Stall = 1'b0;
      tick();
      check("br_target_w", Out[INSTR_HI:INSTR_LO], 69'h0ABC);
      tick(); tick();

      // Interrupt pulse while in IMM
      Interrupt = 1'b1;
      tick();
      check("irq_imm_bit4", Out[INT_BIT], 69'd0);
      check("irq_imm_flag", Out[IMMW_BIT], 69'd1);
      Interrupt = 1'b0;
      tick();
      check("irq_next_bit4", Out[INT_BIT], 69'd1);
      tick();
      check("irq_clear_bit4", Out[INT_BIT], 69'd0);

      // Reset while in IMM at PC=0x20
      Branch = 1'b1; BranchTarget = 32'h1F;
      tick();
      Branch = 1'b0;
      tick();
      check("pre_rst_addr", {37'b0, ImemAddr}, 69'h20);
      Rst = 1'b0;
      tick();
      check("mid_imm_rst_out", Out, 69'd0);
      check("mid_imm_rst_addr", {37'b0, ImemAddr}, 69'd0);
      Rst = 1'b1;
      tick();
      check("post_rst_fetch", Out[IMMW_BIT], 69'd0);

      // Flush holds PC
      Flush = 1'b1;
      tick();
      check("flush_out", Out, 69'd0);
      check("flush_addr", {37'b0, ImemAddr}, 69'd1);
      Flush = 1'b0;
      tick();
      check("flush_refetch", Out[INSTR_HI:INSTR_LO], 69'h2345);

      // PC wrap
      Branch = 1'b1; BranchTarget = 32'hFFFF_FFFF;
      tick();
      Branch = 1'b0;
      tick();
      check("wrap_next", Out[ADDR_HI:ADDR_LO], 69'd0);
      check("wrap_addr", {37'b0, ImemAddr}, 69'd0);

      // Random traffic against the model
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      for (int c = 0; c < 400; c++) begin
         Rst          = ($urandom_range(0, 99) != 0);
         Branch       = ($urandom_range(0, 99) < 6);
         Flush        = ($urandom_range(0, 99) < 6);
         Stall        = ($urandom_range(0, 99) < 20);
         Interrupt    = ($urandom_range(0, 99) < 10);
         InPort       = 16'($urandom);
         BranchTarget = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                    : 32'($urandom_range(0, 1023));
         tick();
      end

      idle_inputs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
